// File: rtl/fifo4_rr_arbiter_if.sv
// Handshake bundle for the two-writer, one-reader FIFO controller:
// two producer request/grant/data groups, the consumer read port and status.
interface fifo4_rr_arbiter_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH);

    logic          req0;
    logic [DW-1:0] data0;
    logic          gnt0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          gnt1;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          err;

    // Driver side: producers and consumer
    modport master (
        output req0, data0, req1, data1, rd_en,
        input  gnt0, gnt1, rd_data, rd_valid, count, full, empty, err
    );

    // Controller side
    modport slave (
        input  req0, data0, req1, data1, rd_en,
        output gnt0, gnt1, rd_data, rd_valid, count, full, empty, err
    );
endinterface

// File: rtl/fifo4_rr_arbiter.sv
// Two-writer, one-reader FIFO controller. A round-robin arbiter shares the
// single write port between producer 0 and producer 1; the consumer drains
// through a registered read port. Grants are combinational so a producer
// sees in the same cycle that its word is taken at the coming edge.
module fifo4_rr_arbiter #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo4_rr_arbiter_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // Arbiter state: index of the most recent winner
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_t;

    last_t         last_q, last_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;

    logic          gnt0_s, gnt1_s;
    logic          wr_en_s;
    logic          rd_fire_s;
    logic [DW-1:0] wr_data_s;
    logic          full_s, empty_s;

    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == '0);
    assign wr_en_s   = gnt0_s | gnt1_s;
    assign rd_fire_s = bus.rd_en & ~empty_s & ~reset;

    // Round-robin grant: no grant during reset or while full; a tie goes
    // to the producer that did not win last time
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset || full_s) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            if (last_q == LAST1) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.req0) begin
            gnt0_s = 1'b1;
        end else if (bus.req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Select the winning producer's word for the write port
    always_comb begin
        wr_data_s = bus.data0;
        if (gnt1_s) begin
            wr_data_s = bus.data1;
        end else begin
            wr_data_s = bus.data0;
        end
    end

    // Next-state for arbiter, pointers, occupancy and the read port
    always_comb begin
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;

        if (gnt0_s) begin
            last_d = LAST0;
        end else if (gnt1_s) begin
            last_d = LAST1;
        end else begin
            last_d = last_q;
        end

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_fire_s) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end

        // Underflow flag: a pop request that finds the FIFO empty
        if (bus.rd_en && empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        // Simultaneous write and pop leave occupancy unchanged
        case ({wr_en_s, rd_fire_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; reset suppresses all activity
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= LAST1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage array; contents are deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    assign bus.gnt0     = gnt0_s;
    assign bus.gnt1     = gnt1_s;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.full     = full_s;
    assign bus.empty    = empty_s;
    assign bus.err      = err_q;
endmodule

// File: doc/fifo4_rr_arbiter.md
Name: fifo4_rr_arbiter

Overview:
- Two-writer, one-reader controller for a 4-deep FIFO. Owns the storage array, the read and write pointers, and the occupancy count.
- Shares the single FIFO write port between producer 0 and producer 1 with a round-robin arbiter.
- Drains to one consumer through a registered read port.
- Sits between two upstream byte sources and a downstream sink in the embedded datapath.

Parameters:
- DW, 8, data width of every write and read word.
- DEPTH, 4, number of entries. Must be a power of two. PW = log2(DEPTH) is derived, 2 at default.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req0  in  1  producer 0 write request.
- data0  in  DW  producer 0 write data.
- gnt0  out  1  combinational grant; producer 0's word is written at this clock edge.
- req1  in  1  producer 1 write request.
- data1  in  DW  producer 1 write data.
- gnt1  out  1  combinational grant for producer 1.
- rd_en  in  1  consumer pop request.
- rd_data  out  DW  registered read word.
- rd_valid  out  1  rd_data holds a popped word. One-cycle pulse per pop.
- count  out  PW+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  1  one-cycle pulse when rd_en is asserted while empty.

Behaviour:
- Reset (reset=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_data=0, err=0, last=1.
  - Storage contents are not cleared.
  - Reset overrides all same-cycle requests; no write or pop occurs.
- Arbiter state is the 1-bit register last (LAST0/LAST1), recording the most recent winner.
- Grant logic is combinational from req0, req1, full, last and reset. While reset=1 or full=1: gnt0=gnt1=0.
  - Only req0 asserted: gnt0=1.
  - Only req1 asserted: gnt1=1.
  - Both asserted: grant the requester that is not last. After reset, last=1, so producer 0 wins the first tie.
  - At most one grant per cycle; gnt0 and gnt1 are never both 1.
- Grant updates: on a grant, last takes the winner's index at the edge. With no grant, last holds.
- Write: at the edge where a grant is active, mem[wr_ptr] <= winner data and wr_ptr <= wr_ptr+1, with natural PW-bit wrap (3 -> 0).
- Read: rd_en && !empty at an edge:
  - rd_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1 (wraps).
  - rd_valid=1 in the following cycle. Latency is 1 cycle from rd_en to data.
  - Without a pop, rd_valid=0 and rd_data holds its last value.
- Underflow: rd_en && empty gives no pointer or count change, rd_valid=0, and err=1 for one cycle.
- Full: no grant is issued while full, even if rd_en is asserted the same cycle (no write-through-full). The refused producer keeps req high and is granted next cycle.
- Count update, evaluated per edge:
  - Write only: +1.
  - Pop only: -1.
  - Write and pop in the same cycle (possible only when 0 < count < DEPTH): unchanged.
  - count never exceeds DEPTH and never underflows.
- Same-cycle write and read at the same pointer is impossible, because a read needs count ≥ 1 and a write needs count ≤ DEPTH-1. A read therefore always returns the previously written word.
- full and empty are decoded from the registered count and are valid from the cycle after reset.
- Ordering: words are read in the order in which they were granted.

Test Plan:
- Reset, then idle: count=0, empty=1, full=0, rd_valid=0, gnt0=gnt1=0. Assert rd_en for one cycle -> err=1 for exactly that cycle; count stays 0.
- req0 only with data0=0x11,0x22,0x33,0x44, then a fifth request:
  - gnt0=1 for the first four cycles; count steps 1..4, then full=1.
  - The fifth request sees gnt0=0 while full.
  - Then pop four times -> rd_data 0x11,0x22,0x33,0x44 appears with rd_valid one cycle after each rd_en, and empty=1 at the end.
- req0 and req1 held high from reset, data0=0xA0+n, data1=0xB0+n:
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - Pops return 0xA0, 0xB0, 0xA1, 0xB1.
- count=2 with req1 and rd_en in the same cycle -> gnt1=1, rd_valid next cycle, count stays 2.
- count=4 with req0 and rd_en in the same cycle -> gnt0=0, count=3. The next cycle gnt0=1 and count=4.
- Fill and drain for 10 cycles so both pointers wrap twice -> data order is preserved.
  - Then assert reset mid-stream with req0 and rd_en high -> no grant, count=0, rd_valid=0 in the next cycle, and producer 0 wins the first tie after reset.
